// File: rtl/sampler_ctrl.sv
// Command sequencer for the gated ADC sampler: decodes host commands, arms a capture
// and streams each captured word to the transmit path over a valid/ready handshake.
module sampler_ctrl #(
  parameter int DATA_SIZE    = 8,
  parameter int MEM_DEPTH    = 1024,
  parameter int ABORT_CYCLES = 4,
  parameter int TIMEOUT      = 65535,
  parameter int CNT_SIZE     = 16,
  localparam int WORDS_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd_code,
  input  logic [DATA_SIZE-1:0] i_cmd_arg,
  input  logic [DATA_SIZE-1:0] i_smp_data,
  input  logic                 i_smp_valid,
  input  logic                 i_smp_idle,
  input  logic                 i_tx_ready,
  output logic                 o_adc_init,
  output logic                 o_cmd_decim,
  output logic [DATA_SIZE-1:0] o_cmd_param,
  output logic                 o_sample,
  output logic                 o_next,
  output logic [DATA_SIZE-1:0] o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_cmd_err,
  output logic                 o_timeout,
  output logic [WORDS_W-1:0]   o_words,
  output logic [2:0]           dbg_state
);

  // Stream handshake: a word moves on every rising edge where o_tx_valid and i_tx_ready
  // are both high; o_tx_data stays stable while o_tx_valid waits for i_tx_ready.

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_ARM, S_CAPTURE, S_XFER, S_NEXT, S_ABORT
  } state_t;

  localparam logic [1:0] CMD_SET   = 2'd1;
  localparam logic [1:0] CMD_ARM   = 2'd2;
  localparam logic [1:0] CMD_ABORT = 2'd3;
  localparam int AB_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

  state_t               state, state_d;
  logic [DATA_SIZE-1:0] decim_d, tx_data_d;
  logic [WORDS_W-1:0]   words_d;
  logic [CNT_SIZE-1:0]  to_cnt, to_cnt_d;
  logic [AB_W-1:0]      ab_cnt, ab_cnt_d;
  logic                 last_valid, rise, timeout_d, err_d;
  logic                 is_set, is_arm, is_abort;

  assign rise      = i_smp_valid & ~last_valid;
  assign is_set    = i_cmd_valid && (i_cmd_code == CMD_SET);
  assign is_arm    = i_cmd_valid && (i_cmd_code == CMD_ARM);
  assign is_abort  = i_cmd_valid && (i_cmd_code == CMD_ABORT);
  assign dbg_state = state;

  always_comb begin
    state_d   = state;
    decim_d   = o_cmd_param;
    tx_data_d = o_tx_data;
    words_d   = o_words;
    timeout_d = o_timeout;
    to_cnt_d  = to_cnt;
    ab_cnt_d  = ab_cnt;
    err_d     = (state != S_IDLE) && (is_set || is_arm);
    case (state)
      S_IDLE: begin
        if (is_set) begin
          if (i_cmd_arg != '0) begin
            decim_d = i_cmd_arg;
            state_d = S_CFG;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_arm) begin
          if (i_smp_idle) begin
            words_d   = '0;
            timeout_d = 1'b0;
            state_d   = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_abort) begin
          state_d = S_ABORT;
        end
      end
      S_CFG: state_d = S_IDLE;
      S_ARM: state_d = is_abort ? S_ABORT : S_CAPTURE;
      S_CAPTURE: begin
        if (is_abort) begin
          state_d = S_ABORT;
        end else if (rise) begin
          tx_data_d = i_smp_data;
          state_d   = S_XFER;
        end else if (i_smp_idle && (o_words != '0)) begin
          state_d = S_IDLE;
        end else if (to_cnt == CNT_SIZE'(TIMEOUT - 1)) begin
          // CAPTURE has now lasted TIMEOUT cycles without a fresh word
          timeout_d = 1'b1;
          state_d   = S_ABORT;
        end else begin
          to_cnt_d = to_cnt + CNT_SIZE'(1);
        end
      end
      S_XFER: begin
        if (i_tx_ready) begin
          if (o_words != WORDS_W'(MEM_DEPTH)) words_d = o_words + WORDS_W'(1);
          state_d = S_NEXT;
        end
        if (is_abort) state_d = S_ABORT;
      end
      S_NEXT: begin
        if (is_abort)                              state_d = S_ABORT;
        else if (o_words == WORDS_W'(MEM_DEPTH))   state_d = S_IDLE;
        else                                       state_d = S_CAPTURE;
      end
      S_ABORT: begin
        if (ab_cnt == AB_W'(ABORT_CYCLES - 1)) state_d = S_CFG;
        else                                   ab_cnt_d = ab_cnt + AB_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_CAPTURE && state != S_CAPTURE) to_cnt_d = '0;
    if (state_d == S_ABORT && state != S_ABORT)     ab_cnt_d = '0;
  end

  // Strobes are registered from the next state so each one lines up with its state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      ab_cnt      <= '0;
      last_valid  <= 1'b0;
      o_adc_init  <= 1'b1;
      o_cmd_decim <= 1'b0;
      o_cmd_param <= DATA_SIZE'(4);
      o_sample    <= 1'b0;
      o_next      <= 1'b0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_cmd_err   <= 1'b0;
      o_timeout   <= 1'b0;
      o_words     <= '0;
    end else begin
      state       <= state_d;
      to_cnt      <= to_cnt_d;
      ab_cnt      <= ab_cnt_d;
      last_valid  <= i_smp_valid;
      o_adc_init  <= (state_d != S_ABORT);
      o_cmd_decim <= (state_d == S_CFG);
      o_cmd_param <= decim_d;
      o_sample    <= (state_d == S_ARM);
      o_next      <= (state_d == S_NEXT);
      o_tx_data   <= tx_data_d;
      o_tx_valid  <= (state_d == S_XFER);
      o_busy      <= (state_d != S_IDLE);
      o_cmd_err   <= err_d;
      o_timeout   <= timeout_d;
      o_words     <= words_d;
    end
  end

endmodule

// File: doc/sampler_ctrl.md
Name: sampler_ctrl

Overview:
Command-driven sequencer for the gated ADC sampler and its capture memory.
- Decodes host commands (set decimation, arm, abort) into the sampler's configuration and control strobes.
- After capture completes, walks the sampler through readout one word at a time and forwards each word over a valid/ready stream to the transmit path.
- Restores the stored decimation after every abort.

Parameters:
DATA_SIZE, 8, width of sample words, command argument and decimation value
MEM_DEPTH, 1024, capture memory depth in words; upper bound of o_words
ABORT_CYCLES, 4, cycles o_adc_init is held low during abort (>=1)
TIMEOUT, 65535, max cycles in CAPTURE without a new valid word before auto-abort
CNT_SIZE, 16, width of timeout counter

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  host command strobe, one cycle per command
i_cmd_code  in  2  1=SET_DECIM, 2=ARM, 3=ABORT, 0=NOP
i_cmd_arg  in  DATA_SIZE  SET_DECIM argument
i_smp_data  in  DATA_SIZE  sampler data output
i_smp_valid  in  1  sampler word-valid (multi-cycle high)
i_smp_idle  in  1  sampler in init state
i_tx_ready  in  1  transmit path ready
o_adc_init  out  1  sampler enable; low forces sampler to init and default decimation
o_cmd_decim  out  1  decimation load strobe
o_cmd_param  out  DATA_SIZE  decimation value
o_sample  out  1  arm pulse
o_next  out  1  advance-to-next-word pulse
o_tx_data  out  DATA_SIZE  word to transmit
o_tx_valid  out  1  o_tx_data valid
o_busy  out  1  state != IDLE
o_cmd_err  out  1  one-cycle pulse on a rejected command
o_timeout  out  1  sticky until next accepted ARM
o_words  out  11  words forwarded in the current or last readout (clog2(MEM_DEPTH)+1)

Behaviour:
- Reset: state=IDLE.
  - Reset values: o_adc_init=1, o_cmd_decim=0, o_sample=0, o_next=0, o_tx_valid=0, o_cmd_err=0, o_timeout=0, o_words=0, o_tx_data=0.
  - Stored decim register=4; o_cmd_param=4.
- All outputs are registered.
- Valid edge detect: rise = i_smp_valid & ~last_valid. last_valid is cleared on reset.
- States:
  - IDLE: accepts all commands.
    - SET_DECIM with arg!=0: store arg, go CFG.
    - SET_DECIM with arg==0: o_cmd_err.
    - ARM: if i_smp_idle, clear o_words and o_timeout, go ARM; otherwise o_cmd_err.
    - ABORT: go ABORT.
  - CFG: o_cmd_decim=1, o_cmd_param=stored for exactly 1 cycle, then IDLE.
  - ARM: o_sample=1 for 1 cycle, then CAPTURE.
  - CAPTURE:
    - On rise: latch i_smp_data into o_tx_data, go XFER.
    - Else if i_smp_idle && o_words!=0 (sampler finished): go IDLE.
    - Timeout counter increments each cycle and clears on entry to CAPTURE. When it reaches TIMEOUT, set o_timeout and go ABORT.
  - XFER: o_tx_valid=1 and o_tx_data held stable until the cycle i_tx_ready=1. In that cycle: transfer, o_words+1, go NEXT.
  - NEXT: o_next=1 for 1 cycle.
    - If o_words==MEM_DEPTH, go IDLE.
    - Else go CAPTURE.
  - ABORT: o_adc_init=0 for ABORT_CYCLES cycles, then o_adc_init=1 and go CFG to re-apply the stored decimation.
- Commands outside IDLE:
  - ABORT is accepted in every state except ABORT and CFG, where it is ignored without error. On acceptance, o_tx_valid drops next cycle.
  - SET_DECIM and ARM outside IDLE raise o_cmd_err and are otherwise ignored.
- A command and a state exit in the same cycle: the command is evaluated in the current state.
- o_words saturates at MEM_DEPTH.
- Reset mid-operation returns everything to reset values, including stored decim=4.

Test Plan:
- Reset, then SET_DECIM arg=8 -> next cycle o_cmd_decim=1 with o_cmd_param=8 for one cycle; o_busy high 1 cycle.
- SET_DECIM arg=0 -> o_cmd_err pulses once; no o_cmd_decim; stored decim stays 4.
- ARM with i_smp_idle=1, then a sampler model drives 3 valid bursts (data 0x11, 0x22, 0x33) and i_tx_ready always 1, then idle:
  - exactly 3 o_tx_valid beats carrying 0x11, 0x22, 0x33;
  - 3 o_next pulses;
  - o_words=3;
  - return to IDLE.
- Backpressure: i_tx_ready low 10 cycles during XFER -> o_tx_data/o_tx_valid stable for 10 cycles; o_next fires only after the handshake.
- ABORT during CAPTURE after SET_DECIM 6 -> o_adc_init low for exactly 4 cycles, then o_cmd_decim pulse with o_cmd_param=6, then IDLE; ARM issued during the abort raises o_cmd_err.
- TIMEOUT=20, ARM with no valid from the sampler -> 20 cycles later o_timeout=1 and the abort sequence runs; the next accepted ARM clears o_timeout.
